uart_tx_feeder: RTL and testbench
=================================

# uart_tx_feeder

Upstream stage for the UART transmitter: buffers bytes from a producer in a FIFO and drives the UART's `data` / `up_data` load interface. The UART has no busy flag, so this block paces loads to one per frame time. It sits between the system producer and the UART `data` / `up_data` inputs, one instance per UART.

## Interface
- `N`, 8: data word width; matches UART `N`.
- `DEPTH`, 16: FIFO depth in words; power of two, ≥ 2.
- `FRAME_CYCLES`, 8680: minimum clk cycles between consecutive `up_data` pulses. 10-bit frame at 115200 baud from 100 MHz. Must be ≥ 2.

- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `wr_data`  in  N  word to transmit.
- `wr_valid`  in  1  producer offers `wr_data`.
- `wr_ready`  out  1  FIFO not full; word accepted on an edge with `wr_valid && wr_ready`.
- `flush`  in  1  discard all buffered words.
- `data`  out  N  word presented to the UART; registered, held between loads.
- `up_data`  out  1  single-cycle load strobe to the UART; registered.
- `level`  out  $clog2(DEPTH+1)  current FIFO occupancy.

## Operation
- **Reset** (asynchronous, any time, including mid-gap):
  - `data` = 0, `up_data` = 0, `level` = 0, `wr_ready` = 1.
  - State = IDLE, gap counter = 0, pointers = 0.
- **FIFO**
  - `wr_ready = (level != DEPTH)`, combinational from registered `level`.
  - When full, a write is refused even if a pop occurs on the same edge.
- **FSM** (states IDLE, GAP):
  - **IDLE**, FIFO non-empty at the edge (launch):
    - `data` <= FIFO head, `up_data` <= 1, pop.
    - Gap counter <= `FRAME_CYCLES` − 1; state <= GAP.
  - **IDLE**, FIFO empty: `up_data` <= 0.
  - **GAP**, counter ≠ 0: `up_data` <= 0, counter decrements.
  - **GAP**, counter == 0:
    - FIFO non-empty: launch exactly as from IDLE, with no IDLE cycle in between.
    - FIFO empty: state <= IDLE.
- **Pacing**: successive `up_data` pulses are exactly `FRAME_CYCLES` apart while the FIFO stays non-empty, and never closer.
- **Order**: words leave in strict FIFO order. No loss, no duplication.
- **Simultaneous write and pop**: both take effect; `level` is unchanged.
- **Flush**:
  - Takes effect on the edge it is high: pointers and `level` return to 0, and a same-edge write is dropped.
  - FSM state, gap counter, `data` and `up_data` are not affected. A word already launched completes.
  - A flush on a launch edge wins: no pop and no pulse.
- Gap counter width: $clog2(`FRAME_CYCLES`).

## Timing
- **Write-to-strobe latency**: word accepted at edge W into an empty FIFO while IDLE gives `up_data` high in the cycle after edge W+1.
- `data` changes only on launch edges and is valid in the same cycle `up_data` is high.
- `wr_ready` drops in the cycle after the edge that fills the FIFO. It rises in the cycle after the pop or flush edge.
- `up_data` is never high for two consecutive cycles.

## Configuration
- Macro: `UART_TX_FEEDER_STAT_EN`.
- **Defined**, three extra ports:
  - `sent_cnt` out 16: wrapping count of `up_data` pulses.
  - `full_hit` out 1: sticky, set on any edge with `wr_valid && !wr_ready`.
  - `stat_clr` in 1: synchronous clear of both.
  - Both outputs reset to 0. If a set and `stat_clr` occur on the same edge, `stat_clr` wins.
- **Undefined**: these ports and their logic do not exist. All other behaviour is identical.

## Structure
- Package `uart_tx_feeder_pkg`:
  - state enum `feed_state_t` {IDLE, GAP};
  - localparam default `FRAME_CYCLES`;
  - `STAT_W` = 16.
- Sub-module `uart_feed_fifo`: synchronous FIFO with write/pop/flush and `level` output. The FSM and pacing stay in the top module.

## Test plan
- **Single word**: `FRAME_CYCLES`=4, write 0xA5 at edge 10 → `up_data` high during cycle after edge 11, `data`=0xA5, `level` back to 0.
- **Back-to-back**: `FRAME_CYCLES`=4, burst-write 0x01..0x05 → five pulses exactly 4 cycles apart carrying 0x01..0x05 in order, then IDLE.
- **Full**: `DEPTH`=4, `FRAME_CYCLES`=50, write 6 words back-to-back → first pops immediately, the next 4 fill the FIFO, `wr_ready`=0, 6th refused. With the stat macro, `full_hit`=1.
- **Flush mid-gap**: 3 words queued, `flush` one cycle during GAP after first pulse → no further pulses, `level`=0, first word's gap still completes before the next launch.
- **Reset mid-gap**: assert `rst` 2 cycles after a pulse → all outputs 0 immediately. After release, a new write launches with the normal 1-cycle latency.
- **Stats**: macro defined, send 3 words, then `stat_clr` → `sent_cnt` reads 3, then 0. Build without the macro also compiles and passes the single-word test.

Source files
------------

// File: rtl/uart_tx_feeder_pkg.sv
// Shared types and defaults for the UART TX feeder.
package uart_tx_feeder_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    GAP  = 1'b1
  } feed_state_t;

  localparam int FRAME_CYCLES_DEFAULT = 8680;
  localparam int STAT_W               = 16;

endpackage

// File: rtl/uart_feed_fifo.sv
// Synchronous word FIFO with flush for the UART TX feeder.
// Flush wins over a same-edge write or pop; a full FIFO refuses writes even while popping.
module uart_feed_fifo #(
  parameter int N     = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N-1:0]               wr_data,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic                       pop,
  input  logic                       flush,
  output logic [N-1:0]               head,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  logic [N-1:0]  mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [LW-1:0] level_r;
  logic          push_s;
  logic          pop_s;

  assign wr_ready = (level_r != LW'(DEPTH));
  assign empty    = (level_r == {LW{1'b0}});
  assign push_s   = wr_valid && wr_ready && !flush;
  assign pop_s    = pop && !empty && !flush;
  assign head     = mem_r[rd_ptr_r];
  assign level    = level_r;

  // Word storage, written on accepted pushes only.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      level_r  <= {LW{1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      level_r  <= {LW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   level_r <= level_r + LW'(1);
        2'b01:   level_r <= level_r - LW'(1);
        default: level_r <= level_r;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers producer bytes and paces UART loads to one per frame time.
// Optional statistics ports are enabled with `define UART_TX_FEEDER_STAT_EN.
module uart_tx_feeder
  import uart_tx_feeder_pkg::*;
#(
  parameter int N            = 8,
  parameter int DEPTH        = 16,
  parameter int FRAME_CYCLES = FRAME_CYCLES_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N-1:0]               wr_data,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic                       flush,
  output logic [N-1:0]               data,
  output logic                       up_data,
  output logic [$clog2(DEPTH+1)-1:0] level
`ifdef UART_TX_FEEDER_STAT_EN
  ,
  output logic [STAT_W-1:0]          sent_cnt,
  output logic                       full_hit,
  input  logic                       stat_clr
`endif
);

  localparam int                CW         = $clog2(FRAME_CYCLES);
  localparam logic [CW-1:0]     GAP_RELOAD = CW'(FRAME_CYCLES - 1);

  feed_state_t   state_r;
  logic [CW-1:0] gap_cnt_r;
  logic [N-1:0]  head_s;
  logic          empty_s;
  logic          launch_s;

  // A launch needs a word, no flush, and either idle or an expired gap.
  assign launch_s = !empty_s && !flush &&
                    ((state_r == IDLE) || (gap_cnt_r == {CW{1'b0}}));

  uart_feed_fifo #(
    .N     (N),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_data  (wr_data),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .pop      (launch_s),
    .flush    (flush),
    .head     (head_s),
    .empty    (empty_s),
    .level    (level)
  );

  // Pacing FSM with registered load interface.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      gap_cnt_r <= {CW{1'b0}};
      data      <= {N{1'b0}};
      up_data   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (launch_s) begin
            data      <= head_s;
            up_data   <= 1'b1;
            gap_cnt_r <= GAP_RELOAD;
            state_r   <= GAP;
          end else begin
            up_data   <= 1'b0;
          end
        end
        GAP: begin
          if (gap_cnt_r != {CW{1'b0}}) begin
            up_data   <= 1'b0;
            gap_cnt_r <= gap_cnt_r - CW'(1);
          end else if (launch_s) begin
            data      <= head_s;
            up_data   <= 1'b1;
            gap_cnt_r <= GAP_RELOAD;
          end else begin
            up_data   <= 1'b0;
            state_r   <= IDLE;
          end
        end
        default: begin
          up_data   <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

`ifdef UART_TX_FEEDER_STAT_EN
  // Load counter and sticky overflow flag; clear beats a same-edge set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sent_cnt <= {STAT_W{1'b0}};
      full_hit <= 1'b0;
    end else if (stat_clr) begin
      sent_cnt <= {STAT_W{1'b0}};
      full_hit <= 1'b0;
    end else begin
      if (launch_s) begin
        sent_cnt <= sent_cnt + STAT_W'(1);
      end
      if (wr_valid && !wr_ready) begin
        full_hit <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed self-checking bench for uart_tx_feeder (DEPTH=4, FRAME_CYCLES=4).
module tb_uart_tx_feeder;

  localparam int N     = 8;
  localparam int DEPTH = 4;
  localparam int FC    = 4;
  localparam int LW    = $clog2(DEPTH + 1);

  logic          clk      = 1'b0;
  logic          rst      = 1'b1;
  logic [N-1:0]  wr_data  = 8'h00;
  logic          wr_valid = 1'b0;
  logic          flush    = 1'b0;
  logic          wr_ready;
  logic [N-1:0]  data;
  logic          up_data;
  logic [LW-1:0] level;
`ifdef UART_TX_FEEDER_STAT_EN
  logic [15:0]   sent_cnt;
  logic          full_hit;
  logic          stat_clr = 1'b0;
`endif

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;
  int start   = 0;
  int         pulse_cyc[$];
  logic [7:0] pulse_dat[$];

  uart_tx_feeder #(
    .N            (N),
    .DEPTH        (DEPTH),
    .FRAME_CYCLES (FC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_data  (wr_data),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .flush    (flush),
    .data     (data),
    .up_data  (up_data),
    .level    (level)
`ifdef UART_TX_FEEDER_STAT_EN
    ,
    .sent_cnt (sent_cnt),
    .full_hit (full_hit),
    .stat_clr (stat_clr)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, sample 1 time unit later, and log any load pulse.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (up_data === 1'b1) begin
      pulse_cyc.push_back(cyc);
      pulse_dat.push_back(data);
    end
  endtask

  task automatic clear_log();
    pulse_cyc.delete();
    pulse_dat.delete();
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    chk("rst_data", 32'(data), 32'h0);
    chk("rst_up", 32'(up_data), 32'h0);
    chk("rst_level", 32'(level), 32'h0);
    chk("rst_wr_ready", 32'(wr_ready), 32'h1);
    rst = 1'b0;
    tick();

    // Single word: write at W, pulse visible after W+1
    wr_valid = 1'b1; wr_data = 8'hA5;
    tick();
    wr_valid = 1'b0;
    chk("single_level_w", 32'(level), 32'h1);
    chk("single_up_w", 32'(up_data), 32'h0);
    tick();
    chk("single_up", 32'(up_data), 32'h1);
    chk("single_data", 32'(data), 32'hA5);
    chk("single_level0", 32'(level), 32'h0);
    tick();
    chk("single_up_drop", 32'(up_data), 32'h0);
    chk("single_data_hold", 32'(data), 32'hA5);
    repeat (3) tick();

    // Back-to-back burst 0x01..0x05
    clear_log();
    start = cyc;
    for (int i = 0; i < 5; i++) begin
      wr_valid = 1'b1; wr_data = 8'(i + 1);
      tick();
    end
    wr_valid = 1'b0;
    repeat (25) tick();
    chk("b2b_count", 32'(pulse_dat.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      chk("b2b_data", 32'(pulse_dat[i]), 32'(i + 1));
      chk("b2b_cycle", 32'(pulse_cyc[i] - start), 32'(2 + FC * i));
    end

    // Full: 6 words back-to-back, 6th refused
    wr_valid = 1'b1; wr_data = 8'h10; tick();
    wr_data = 8'h11; tick();
    chk("full_first_up", 32'(up_data), 32'h1);
    chk("full_first_data", 32'(data), 32'h10);
    wr_data = 8'h12; tick();
    wr_data = 8'h13; tick();
    wr_data = 8'h14; tick();
    chk("full_level", 32'(level), 32'h4);
    chk("full_wr_ready", 32'(wr_ready), 32'h0);
    wr_data = 8'h15; tick();
    wr_valid = 1'b0;
    chk("full_refused_level", 32'(level), 32'h3);
    chk("full_pop_up", 32'(up_data), 32'h1);
    chk("full_pop_data", 32'(data), 32'h11);
    chk("full_ready_back", 32'(wr_ready), 32'h1);
`ifdef UART_TX_FEEDER_STAT_EN
    chk("full_hit", 32'(full_hit), 32'h1);
`endif
    clear_log();
    repeat (16) tick();
    chk("full_drain_count", 32'(pulse_dat.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      chk("full_drain_data", 32'(pulse_dat[i]), 32'(8'h12 + i));
    end
    repeat (2) tick();

    // Flush mid-gap, same-edge write dropped, gap still completes
    wr_valid = 1'b1; wr_data = 8'h21; tick();
    wr_data = 8'h22; tick();
    chk("flush_first_up", 32'(up_data), 32'h1);
    chk("flush_first_data", 32'(data), 32'h21);
    wr_data = 8'h23; flush = 1'b1; tick();
    flush = 1'b0;
    chk("flush_level", 32'(level), 32'h0);
    wr_data = 8'h24; tick();
    wr_valid = 1'b0;
    chk("flush_drop_level", 32'(level), 32'h1);
    chk("flush_no_pulse_a", 32'(up_data), 32'h0);
    tick();
    chk("flush_no_pulse_b", 32'(up_data), 32'h0);
    tick();
    chk("flush_next_up", 32'(up_data), 32'h1);
    chk("flush_next_data", 32'(data), 32'h24);
    repeat (4) tick();

    // Reset mid-gap
    wr_valid = 1'b1; wr_data = 8'h31; tick();
    wr_data = 8'h32; tick();
    wr_valid = 1'b0;
    chk("rmg_up", 32'(up_data), 32'h1);
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("rmg_data", 32'(data), 32'h0);
    chk("rmg_up0", 32'(up_data), 32'h0);
    chk("rmg_level", 32'(level), 32'h0);
    chk("rmg_wr_ready", 32'(wr_ready), 32'h1);
    tick();
    rst = 1'b0;
    wr_valid = 1'b1; wr_data = 8'h33; tick();
    wr_valid = 1'b0;
    chk("rmg_after_level", 32'(level), 32'h1);
    chk("rmg_after_up0", 32'(up_data), 32'h0);
    tick();
    chk("rmg_after_up", 32'(up_data), 32'h1);
    chk("rmg_after_data", 32'(data), 32'h33);
    repeat (4) tick();

`ifdef UART_TX_FEEDER_STAT_EN
    // Statistics: count three loads, then clear
    chk("stat_full_hit_rst", 32'(full_hit), 32'h0);
    stat_clr = 1'b1; tick();
    stat_clr = 1'b0;
    chk("stat_clr0", 32'(sent_cnt), 32'h0);
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1'b1; wr_data = 8'(8'h40 + i);
      tick();
    end
    wr_valid = 1'b0;
    repeat (12) tick();
    chk("stat_sent3", 32'(sent_cnt), 32'h3);
    stat_clr = 1'b1; tick();
    stat_clr = 1'b0;
    chk("stat_cleared", 32'(sent_cnt), 32'h0);
    chk("stat_full_clear", 32'(full_hit), 32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
